decode_stage: RTL
=================

Name: decode_stage

Overview:
- Instruction decode stage, directly downstream of the fetch unit in the RV32I core.
- Accepts one {pc, instruction} beat per cycle over a valid/ready handshake.
- Decodes register indices, the sign-extended immediate, ALU operation, operation class and illegal flag.
- Presents the result from a single registered output slot to execute, with stall and flush support.

Parameters:
- DATA_WIDTH, 32, width of pc, instruction and immediate.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch beat valid
- if_ready  out  1  stage can accept a beat this cycle
- if_pc  in  DATA_WIDTH  address of the instruction
- if_instruction  in  DATA_WIDTH  raw instruction word
- flush  in  1  discard held and incoming beats (branch redirect)
- id_valid  out  1  decoded beat valid
- id_ready  in  1  execute accepts the beat
- id_pc  out  DATA_WIDTH  pc of the decoded instruction
- id_rs1, id_rs2, id_rd  out  REG_ADDR_WIDTH  register indices
- id_funct3  out  3  instr[14:12], passed through
- id_imm  out  DATA_WIDTH  sign-extended immediate
- id_alu_op  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
- id_op_class  out  3  ALU_R=0 ALU_I=1 LOAD=2 STORE=3 BRANCH=4 JAL=5 JALR=6 UPPER=7
- id_use_pc  out  1  operand A is pc (AUIPC, JAL, BRANCH target)
- id_illegal  out  1  instruction not supported

Behaviour:
- Reset: id_valid=0, all id_* fields=0. if_ready=0 while rst is high.
- Handshake:
  - if_ready = !rst && (!id_valid || id_ready || flush), combinational.
  - A beat is accepted when if_valid && if_ready && !flush.
  - An accepted beat is decoded combinationally and registered. Outputs are valid the next cycle, so latency is 1 cycle.
  - Full throughput with id_ready held at 1.
- Stall: while id_valid && !id_ready, every id_* output holds stable and if_ready=0.
- Flush:
  - Highest priority after rst.
  - Next cycle id_valid=0. Any incoming beat that cycle is consumed (if_ready=1) and dropped.
  - id_* data fields are don't-care while id_valid=0.
- Simultaneous id_ready and new input: the old beat retires and the new beat loads in the same edge (no bubble).
- Reset mid-stall: the held beat is lost and id_valid=0 on the next cycle.
- Immediates, sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: 0
  - Shift-immediate: zero-extended instr[24:20]
- Field forcing:
  - rs1 = 0 for LUI/AUIPC/JAL.
  - rs2 = 0 except for R, S and B.
  - rd = 0 for S and B.
- ALU ops:
  - LUI: UPPER + PASSB.
  - AUIPC: UPPER + ADD with use_pc=1.
  - LOAD/STORE/JALR: ADD.
  - BRANCH: ADD with use_pc=1. Comparison is selected by funct3 in execute.
  - R/I: ALU op from funct3 with instr[30] (SUB, SRA, SRAI).
- FENCE (0001111): decoded as NOP, i.e. ALU_I, ADD, rd=0, rs1=0, imm=0, illegal=0.
- Illegal cases:
  - instr[1:0] != 11, or an unknown opcode.
  - R-type funct7 not 0000000, or 0100000 with funct3 other than 000/101.
  - Shift-immediate with bad funct7.
  - LOAD with funct3 3, 6 or 7; STORE with funct3 > 2; BRANCH with funct3 2 or 3; JALR with funct3 != 0.
  - SYSTEM (1110011).
- Illegal beat: still passed with id_illegal=1, op_class=0, alu_op=0, rd=0, imm=0 so no writeback occurs.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1) at pc 0x100, id_ready=1 -> next cycle id_valid=1, ALU_I, ADD, rd=1, rs1=0, imm=0xFFFFFFFF, id_pc=0x100.
- 0x402081B3 (sub x3,x1,x2) then 0xFE000EE3 (beq x0,x0,-4) back-to-back -> consecutive outputs:
  - first: ALU_R, SUB, rs1=1, rs2=2, rd=3
  - second: BRANCH, funct3=0, imm=0xFFFFFFFC, rd=0, use_pc=1
- Two beats with id_ready=0 for 3 cycles -> first beat held stable and if_ready=0; second beat is not accepted until id_ready=1, then delivered 1 cycle later with no loss or duplication.
- flush asserted while a beat is held and if_valid=1 -> next cycle id_valid=0, incoming beat dropped; the following beat decodes normally.
- 0x00000000 and 0x00000073 (ecall) -> id_illegal=1, rd=0, op_class=0. 0x000000B7 (lui x1,0) -> UPPER, PASSB, illegal=0.
- rst asserted mid-stall -> next cycle id_valid=0, all fields 0, if_ready=0 until rst drops.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I instruction decode stage: one registered output slot between fetch and execute,
// with valid/ready handshaking, stall hold and flush.
module decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [DATA_WIDTH-1:0]     if_pc,
  input  logic [DATA_WIDTH-1:0]     if_instruction,
  input  logic                      flush,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [DATA_WIDTH-1:0]     id_pc,
  output logic [REG_ADDR_WIDTH-1:0] id_rs1,
  output logic [REG_ADDR_WIDTH-1:0] id_rs2,
  output logic [REG_ADDR_WIDTH-1:0] id_rd,
  output logic [2:0]                id_funct3,
  output logic [DATA_WIDTH-1:0]     id_imm,
  output logic [3:0]                id_alu_op,
  output logic [2:0]                id_op_class,
  output logic                      id_use_pc,
  output logic                      id_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
    ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_ALU_R = 3'd0, CLS_ALU_I = 3'd1, CLS_LOAD = 3'd2, CLS_STORE = 3'd3,
    CLS_BRANCH = 3'd4, CLS_JAL = 3'd5, CLS_JALR = 3'd6, CLS_UPPER = 3'd7
  } op_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0]     instr_s;
  logic [6:0]                opcode_s;
  logic [6:0]                funct7_s;
  logic [2:0]                funct3_s;
  logic [DATA_WIDTH-1:0]     imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_sh_s;
  logic [REG_ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
  logic [DATA_WIDTH-1:0]     imm_s;
  alu_op_t                   alu_s;
  op_class_t                 cls_s;
  logic                      use_pc_s;
  logic                      bad_s;
  logic                      illegal_s;
  logic                      accept_s;

  assign instr_s  = if_instruction;
  assign opcode_s = instr_s[6:0];
  assign funct3_s = instr_s[14:12];
  assign funct7_s = instr_s[31:25];

  assign imm_i_s  = {{(DATA_WIDTH-12){instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s  = {{(DATA_WIDTH-12){instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s  = {{(DATA_WIDTH-13){instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s  = {instr_s[DATA_WIDTH-1:12], 12'b0};
  assign imm_j_s  = {{(DATA_WIDTH-21){instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
  assign imm_sh_s = {{(DATA_WIDTH-5){1'b0}}, instr_s[24:20]};

  // Opcode decode: field selection, forcing and per-format legality
  always_comb begin
    rs1_s    = instr_s[15 +: REG_ADDR_WIDTH];
    rs2_s    = instr_s[20 +: REG_ADDR_WIDTH];
    rd_s     = instr_s[7 +: REG_ADDR_WIDTH];
    imm_s    = '0;
    alu_s    = ALU_ADD;
    cls_s    = CLS_ALU_R;
    use_pc_s = 1'b0;
    bad_s    = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        alu_s = alu_from_funct3(funct3_s, instr_s[30]);
        if (funct7_s == F7_BASE) begin
          bad_s = 1'b0;
        end else if (funct7_s == F7_ALT && (funct3_s == 3'b000 || funct3_s == 3'b101)) begin
          bad_s = 1'b0;
        end else begin
          bad_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        cls_s = CLS_ALU_I;
        rs2_s = '0;
        alu_s = alu_from_funct3(funct3_s, (funct3_s == 3'b101) && instr_s[30]);
        if (funct3_s == 3'b001) begin
          imm_s = imm_sh_s;
          bad_s = (funct7_s != F7_BASE);
        end else if (funct3_s == 3'b101) begin
          imm_s = imm_sh_s;
          bad_s = !(funct7_s == F7_BASE || funct7_s == F7_ALT);
        end else begin
          imm_s = imm_i_s;
          bad_s = 1'b0;
        end
      end
      OPC_LOAD: begin
        cls_s = CLS_LOAD;
        rs2_s = '0;
        imm_s = imm_i_s;
        bad_s = (funct3_s == 3'd3) || (funct3_s == 3'd6) || (funct3_s == 3'd7);
      end
      OPC_STORE: begin
        cls_s = CLS_STORE;
        rd_s  = '0;
        imm_s = imm_s_s;
        bad_s = (funct3_s > 3'd2);
      end
      OPC_BRANCH: begin
        cls_s    = CLS_BRANCH;
        rd_s     = '0;
        imm_s    = imm_b_s;
        use_pc_s = 1'b1;
        bad_s    = (funct3_s == 3'd2) || (funct3_s == 3'd3);
      end
      OPC_JAL: begin
        cls_s    = CLS_JAL;
        rs1_s    = '0;
        rs2_s    = '0;
        imm_s    = imm_j_s;
        use_pc_s = 1'b1;
      end
      OPC_JALR: begin
        cls_s = CLS_JALR;
        rs2_s = '0;
        imm_s = imm_i_s;
        bad_s = (funct3_s != 3'd0);
      end
      OPC_LUI: begin
        cls_s = CLS_UPPER;
        alu_s = ALU_PASSB;
        rs1_s = '0;
        rs2_s = '0;
        imm_s = imm_u_s;
      end
      OPC_AUIPC: begin
        cls_s    = CLS_UPPER;
        rs1_s    = '0;
        rs2_s    = '0;
        imm_s    = imm_u_s;
        use_pc_s = 1'b1;
      end
      OPC_FENCE: begin
        cls_s = CLS_ALU_I;
        rs1_s = '0;
        rs2_s = '0;
        rd_s  = '0;
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
  end

  assign illegal_s = bad_s || (instr_s[1:0] != 2'b11);
  assign if_ready  = !rst && (!id_valid || id_ready || flush);
  assign accept_s  = if_valid && if_ready && !flush;

  // Output slot: reset, flush, load (retire+load in one edge), retire, or hold under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_funct3   <= 3'd0;
      id_imm      <= '0;
      id_alu_op   <= 4'd0;
      id_op_class <= 3'd0;
      id_use_pc   <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (accept_s) begin
      // illegal beats are neutralised so execute cannot write back
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_rs1      <= rs1_s;
      id_rs2      <= rs2_s;
      id_rd       <= illegal_s ? '0 : rd_s;
      id_funct3   <= funct3_s;
      id_imm      <= illegal_s ? '0 : imm_s;
      id_alu_op   <= illegal_s ? 4'd0 : alu_s;
      id_op_class <= illegal_s ? 3'd0 : cls_s;
      id_use_pc   <= illegal_s ? 1'b0 : use_pc_s;
      id_illegal  <= illegal_s;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end else begin
      id_valid <= id_valid;
    end
  end

endmodule
